// File: rtl/aes_ctr_stream_if.sv
// rtl/aes_ctr_stream_if.sv - data-in / result-out handshake bundle for aes_ctr_stream
//
// Purpose: groups the input data stream and the result stream of the CTR front end.
// Signals:
//   in_valid, in_ready, in_data[127:0]          : plaintext/ciphertext block into the block
//   out_valid, out_ready, out_data[127:0]       : XORed result block
//   out_ctr[127:0]                              : counter block used to produce out_data
// Modports:
//   master : system data path (drives input stream, consumes results)
//   slave  : aes_ctr_stream
interface aes_ctr_stream_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [127:0] out_ctr;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ctr
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ctr
  );
endinterface

// File: rtl/aes_ctr_stream.sv
// rtl/aes_ctr_stream.sv - AES counter-mode front end around Encryption_Core
//
// Purpose: holds a 128-bit counter block, launches the core once per accepted
// data block, XORs the returned keystream into the data, increments the low
// CTR_WIDTH counter bits and presents the result on a valid/ready output.
// Ports:
//   CLK, RST           : clock, synchronous active-high reset
//   key_ready          : key expansion finished (level); gates new accepts only
//   iv_load, iv[127:0] : load a new counter block (honoured in IDLE only)
//   io (slave)         : in_valid/in_ready/in_data, out_valid/out_ready/out_data/out_ctr
//   core_start         : one-cycle launch pulse to the core
//   core_block[127:0]  : counter block handed to the core, stable while busy
//   core_cipher[127:0] : keystream from the core
//   core_finished      : core done, pulse or level style
//   busy               : high whenever the FSM is not idle
module aes_ctr_stream #(
  parameter int CTR_WIDTH = 128
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             key_ready,
  input  logic             iv_load,
  input  logic [127:0]     iv,
  aes_ctr_stream_if.slave  io,
  output logic             core_start,
  output logic [127:0]     core_block,
  input  logic [127:0]     core_cipher,
  input  logic             core_finished,
  output logic             busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_OUT    = 2'd3;

  // Ones in the counter bits that increment; the remaining upper bits are a fixed nonce.
  localparam logic [127:0] LOW_MASK = {128{1'b1}} >> (128 - CTR_WIDTH);

  logic [1:0]   r_state;
  logic [127:0] r_ctr;
  logic [127:0] r_data_q;
  logic [127:0] r_core_block;
  logic [127:0] r_out_ctr;
  logic [127:0] r_out_data;
  logic         r_fin_q;

  logic         w_idle;
  logic         w_accept;
  logic         w_fin_rise;
  logic [127:0] w_ctr_inc;

  assign w_idle      = (r_state == S_IDLE);
  // iv_load wins over a data accept by holding in_ready low in that cycle.
  assign io.in_ready = w_idle & key_ready & ~iv_load & ~RST;
  assign w_accept    = io.in_valid & io.in_ready;
  // Rising-edge detect lets the core signal done either as a pulse or as a level.
  assign w_fin_rise  = core_finished & ~r_fin_q;
  // Carry out of the low field is dropped, so the low bits wrap modulo 2^CTR_WIDTH.
  assign w_ctr_inc   = (r_ctr & ~LOW_MASK) | ((r_ctr + 128'd1) & LOW_MASK);

  assign io.out_valid = (r_state == S_OUT);
  assign io.out_data  = r_out_data;
  assign io.out_ctr   = r_out_ctr;
  assign core_start   = (r_state == S_LAUNCH);
  assign core_block   = r_core_block;
  assign busy         = ~w_idle;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_ctr        <= '0;
      r_data_q     <= '0;
      r_core_block <= '0;
      r_out_ctr    <= '0;
      r_out_data   <= '0;
      r_fin_q      <= 1'b0;
    end else begin
      r_fin_q <= core_finished;
      case (r_state)
        S_IDLE: begin
          if (iv_load) begin
            r_ctr <= iv;
          end else if (w_accept) begin
            r_data_q     <= io.in_data;
            r_core_block <= r_ctr;
            r_out_ctr    <= r_ctr;
            r_state      <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_fin_rise) begin
            r_out_data <= r_data_q ^ core_cipher;
            r_ctr      <= w_ctr_inc;
            r_state    <= S_OUT;
          end
        end
        S_OUT: begin
          if (io.out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_ctr_stream.sv
// tb/tb_aes_ctr_stream.sv - scoreboard bench for aes_ctr_stream with a stub Encryption_Core
module tb_aes_ctr_stream;

  localparam logic [127:0] IV1 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] IV2 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;
  localparam logic [127:0] PT1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CT1 = 128'h601ec313775789a5b7a7f504bbf3d228;
  localparam logic [127:0] PT2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] CT2 = 128'hf443e3ca4d62b59aca84e990cacaf5c5;
  localparam logic [127:0] KS1 = CT1 ^ PT1;
  localparam logic [127:0] KS2 = CT2 ^ PT2;
  localparam logic [127:0] IV3 = 128'h0123456789abcdef_fedcba9876543210;

  // Stub keystream: the AES-256 NIST keystream for the two NIST counter blocks,
  // an arbitrary invertible scramble for every other counter value.
  function automatic logic [127:0] core_fn(input logic [127:0] b);
    if (b == IV1) return KS1;
    if (b == IV2) return KS2;
    return {b[95:0], b[127:96]} ^ 128'h5a5a5a5a_c3c3c3c3_0f0f0f0f_96969696;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         key_ready;
  logic         iv_load, iv_load1;
  logic [127:0] iv, iv1;
  logic         start0, fin0, busy0, start1, busy1;
  logic [127:0] blk0, cipher0, blk1, cipher1;
  logic         fin1 = 1'b0;

  aes_ctr_stream_if u_if0 ();
  aes_ctr_stream_if u_if1 ();

  aes_ctr_stream #(.CTR_WIDTH(128)) u_dut0 (
    .CLK(clk), .RST(rst), .key_ready(key_ready), .iv_load(iv_load), .iv(iv),
    .io(u_if0), .core_start(start0), .core_block(blk0), .core_cipher(cipher0),
    .core_finished(fin0), .busy(busy0)
  );

  aes_ctr_stream #(.CTR_WIDTH(32)) u_dut1 (
    .CLK(clk), .RST(rst), .key_ready(key_ready), .iv_load(iv_load1), .iv(iv1),
    .io(u_if1), .core_start(start1), .core_block(blk1), .core_cipher(cipher1),
    .core_finished(fin1), .busy(busy1)
  );

  // Core stub for instance 0: configurable latency, pulse or level finished, stray injection.
  int           lat = 3;
  bit           level_mode = 1'b0;
  logic         stray = 1'b0;
  logic [127:0] st_blk = '0;
  logic         st_fin = 1'b0;
  int           st_cnt = 0;
  bit           st_pend = 1'b0;

  always @(posedge clk) begin
    if (!level_mode) st_fin <= 1'b0;
    if (start0) begin
      st_blk  <= blk0;
      st_cnt  <= lat;
      st_pend <= 1'b1;
      st_fin  <= 1'b0;
    end else if (st_pend) begin
      if (st_cnt <= 1) begin
        st_pend <= 1'b0;
        st_fin  <= 1'b1;
      end
      st_cnt <= st_cnt - 1;
    end
  end
  assign cipher0 = core_fn(st_blk);
  assign fin0    = st_fin | stray;

  // Core stub for instance 1: fixed short latency, pulse finished.
  always @(posedge clk) fin1 <= start1;
  assign cipher1 = core_fn(blk1);

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", tag, act, exp);
    else n_pass++;
  endtask

  typedef struct {
    logic [127:0] d;
    logic [127:0] c;
  } exp_t;

  exp_t         sb[$];
  logic [127:0] m_ctr = '0;
  int           acc_cnt = 0, out_cnt = 0, start_cnt = 0;
  logic         prev_start = 1'b0;
  logic [127:0] last_d = '0, last_c = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (u_if0.in_valid && u_if0.in_ready) begin
        exp_t e;
        e.d = u_if0.in_data ^ core_fn(m_ctr);
        e.c = m_ctr;
        sb.push_back(e);
        m_ctr = m_ctr + 128'd1;
        acc_cnt++;
      end
      if (u_if0.out_valid && u_if0.out_ready) begin
        check_eq("sb_nonempty", 128'(sb.size() != 0), 128'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check_eq("out_data", u_if0.out_data, e.d);
          check_eq("out_ctr", u_if0.out_ctr, e.c);
        end
        last_d = u_if0.out_data;
        last_c = u_if0.out_ctr;
        out_cnt++;
      end
      if (start0) begin
        check_eq("start_width", 128'(prev_start), 128'd0);
        start_cnt++;
      end
    end
    prev_start = start0;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [127:0] d);
    int a0 = acc_cnt;
    int n = 0;
    u_if0.in_valid = 1'b1;
    u_if0.in_data  = d;
    while (acc_cnt == a0 && n < 100) begin
      tick();
      n++;
    end
    u_if0.in_valid = 1'b0;
    check_eq("send_accept", 128'(acc_cnt != a0), 128'd1);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || busy0) && n < 200) begin
      tick();
      n++;
    end
    check_eq("drain", 128'(sb.size()), 128'd0);
  endtask

  task automatic load_iv(input logic [127:0] v, input bit taken);
    iv      = v;
    iv_load = 1'b1;
    @(negedge clk);
    check_eq("iv_load_in_ready", 128'(u_if0.in_ready), 128'd0);
    @(posedge clk);
    #1;
    iv_load = 1'b0;
    if (taken) m_ctr = v;
  endtask

  task automatic run1(input logic [127:0] d, input logic [127:0] c, input string tag);
    int n = 0;
    u_if1.in_valid = 1'b1;
    u_if1.in_data  = d;
    @(negedge clk);
    while (!u_if1.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    u_if1.in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!u_if1.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_valid"}, 128'(u_if1.out_valid), 128'd1);
    check_eq({tag, "_ctr"}, u_if1.out_ctr, c);
    check_eq({tag, "_data"}, u_if1.out_data, d ^ core_fn(c));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, a0, n;
    logic [127:0] cap;
    rst = 1'b1; key_ready = 1'b1; iv_load = 1'b0; iv = '0; iv_load1 = 1'b0; iv1 = '0;
    u_if0.in_valid = 1'b0; u_if0.in_data = '0; u_if0.out_ready = 1'b1;
    u_if1.in_valid = 1'b0; u_if1.in_data = '0; u_if1.out_ready = 1'b1;

    // Reset state
    tick();
    @(negedge clk);
    check_eq("rst_in_ready", 128'(u_if0.in_ready), 128'd0);
    check_eq("rst_out_valid", 128'(u_if0.out_valid), 128'd0);
    check_eq("rst_out_data", u_if0.out_data, 128'd0);
    check_eq("rst_out_ctr", u_if0.out_ctr, 128'd0);
    check_eq("rst_core_start", 128'(start0), 128'd0);
    check_eq("rst_core_block", blk0, 128'd0);
    check_eq("rst_busy", 128'(busy0), 128'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_in_ready", 128'(u_if0.in_ready), 128'd1);
    @(posedge clk);
    #1;

    // NIST block 1 and 2
    load_iv(IV1, 1'b1);
    send(PT1);
    @(negedge clk);
    check_eq("launch_cycle", 128'(start0), 128'd1);
    drain();
    check_eq("nist1_data", last_d, CT1);
    check_eq("nist1_ctr", last_c, IV1);
    send(PT2);
    drain();
    check_eq("nist2_data", last_d, CT2);
    check_eq("nist2_ctr", last_c, IV2);

    // Backpressure
    u_if0.out_ready = 1'b0;
    send(128'h11112222333344445555666677778888);
    n = 0;
    while (!u_if0.out_valid && n < 100) begin
      tick();
      n++;
    end
    check_eq("bp_valid", 128'(u_if0.out_valid), 128'd1);
    cap = u_if0.out_data;
    s0 = start_cnt;
    u_if0.in_valid = 1'b1;
    u_if0.in_data  = 128'h9999aaaabbbbccccddddeeeeffff0000;
    repeat (10) begin
      @(negedge clk);
      check_eq("bp_hold", u_if0.out_data, cap);
      check_eq("bp_in_ready", 128'(u_if0.in_ready), 128'd0);
      @(posedge clk);
      #1;
    end
    check_eq("bp_no_start", 128'(start_cnt), 128'(s0));
    a0 = acc_cnt;
    u_if0.out_ready = 1'b1;
    n = 0;
    while (acc_cnt == a0 && n < 100) begin
      tick();
      n++;
    end
    u_if0.in_valid = 1'b0;
    tick(lat + 6);
    check_eq("bp_one_start", 128'(start_cnt), 128'(s0 + 1));
    drain();

    // Counter wrap, 128-bit field
    load_iv({128{1'b1}}, 1'b1);
    send(128'h0badc0de_0badc0de_0badc0de_0badc0de);
    send(128'hfeedface_feedface_feedface_feedface);
    drain();
    check_eq("wrap128", last_c, 128'd0);

    // Counter wrap, 32-bit field (instance 1)
    iv1 = 128'h1_ffffffff;
    iv_load1 = 1'b1;
    tick();
    iv_load1 = 1'b0;
    run1(128'h00000000_00000000_00000000_12345678, 128'h1_ffffffff, "w32a");
    run1(128'hcafebabe_cafebabe_cafebabe_cafebabe, 128'h1_00000000, "w32b");

    // iv_load while busy is ignored, iv_load in idle takes effect
    lat = 4;
    send(128'h13579bdf_2468ace0_13579bdf_2468ace0);
    tick();
    load_iv(IV3, 1'b0);
    drain();
    check_eq("ivload_busy_ctr", last_c, 128'd1);
    send(128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0);
    drain();
    check_eq("ivload_busy_next", last_c, 128'd2);
    u_if0.in_valid = 1'b1;
    u_if0.in_data  = 128'h55555555_aaaaaaaa_55555555_aaaaaaaa;
    load_iv(IV3, 1'b1);
    send(128'h55555555_aaaaaaaa_55555555_aaaaaaaa);
    drain();
    check_eq("ivload_idle_ctr", last_c, IV3);

    // Level-style finished, then a stray finished edge in idle
    level_mode = 1'b1;
    send(128'h01010101_02020202_03030303_04040404);
    send(128'h05050505_06060606_07070707_08080808);
    drain();
    level_mode = 1'b0;
    tick(2);
    s0 = out_cnt;
    stray = 1'b1;
    tick(2);
    stray = 1'b0;
    tick(3);
    check_eq("stray_no_valid", 128'(u_if0.out_valid), 128'd0);
    check_eq("stray_no_out", 128'(out_cnt), 128'(s0));

    // Reset while waiting on the core
    lat = 6;
    send(128'hdeadbeef_deadbeef_deadbeef_deadbeef);
    tick(2);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_wait_in_ready", 128'(u_if0.in_ready), 128'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    m_ctr = '0;
    s0 = out_cnt;
    @(negedge clk);
    check_eq("rstw_out_valid", 128'(u_if0.out_valid), 128'd0);
    check_eq("rstw_out_data", u_if0.out_data, 128'd0);
    check_eq("rstw_out_ctr", u_if0.out_ctr, 128'd0);
    check_eq("rstw_core_start", 128'(start0), 128'd0);
    check_eq("rstw_core_block", blk0, 128'd0);
    check_eq("rstw_busy", 128'(busy0), 128'd0);
    tick(12);
    check_eq("rstw_no_out", 128'(out_cnt), 128'(s0));
    send(128'h77777777_88888888_99999999_aaaaaaaa);
    drain();
    check_eq("rstw_ctr_zero", last_c, 128'd0);

    // Key gating
    key_ready = 1'b0;
    s0 = start_cnt;
    u_if0.in_valid = 1'b1;
    u_if0.in_data  = 128'h3c3c3c3c_3c3c3c3c_3c3c3c3c_3c3c3c3c;
    repeat (5) begin
      @(negedge clk);
      check_eq("key_gate_in_ready", 128'(u_if0.in_ready), 128'd0);
      @(posedge clk);
      #1;
    end
    check_eq("key_gate_no_start", 128'(start_cnt), 128'(s0));
    key_ready = 1'b1;
    send(128'h3c3c3c3c_3c3c3c3c_3c3c3c3c_3c3c3c3c);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
